// File: rtl/dff_bank_sched.sv
// Round-robin scheduler sharing one preset/clear D flip-flop bank among
// NREQ requesters. Each granted operation drives the bank control lines
// for HOLD cycles, reads the bank back, and reports done/rd_data/err.
module dff_bank_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int HOLD  = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_data,
  input  logic [WIDTH-1:0]      bank_q,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  err,
  output logic                  busy,
  output logic [WIDTH-1:0]      bank_d,
  output logic                  bank_we,
  output logic                  bank_pre,
  output logic                  bank_clr
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_DRIVE,
    S_VERIFY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_PRESET = 2'b10,
    OP_READ   = 2'b11
  } op_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    win_q, win_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] bank_d_q, bank_d_d;
  logic             bank_we_q, bank_we_d;
  logic             bank_pre_q, bank_pre_d;
  logic             bank_clr_q, bank_clr_d;

  logic             arb_found;
  logic [IW-1:0]    arb_idx;
  logic [IW-1:0]    arb_try;
  logic [WIDTH-1:0] exp_val;
  logic             drive_d;

  // Round-robin search starting at rr_q, wrapping mod NREQ; first set bit wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_try   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      arb_try = IW'((32'(rr_q) + i) % NREQ);
      if (!arb_found && req[arb_try]) begin
        arb_found = 1'b1;
        arb_idx   = arb_try;
      end
    end
  end

  // Next-state logic plus next values of every registered output.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    op_d      = op_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;

    case (op_q)
      OP_LOAD:   exp_val = data_q;
      OP_CLEAR:  exp_val = '0;
      OP_PRESET: exp_val = '1;
      default:   exp_val = '0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d = S_GRANT;
          win_d   = arb_idx;
          op_d    = op_t'(req_op[2*32'(arb_idx) +: 2]);
          data_d  = req_data[WIDTH*32'(arb_idx) +: WIDTH];
          rr_d    = (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
        end
      end
      S_GRANT: begin
        state_d = S_DRIVE;
        cnt_d   = CW'(HOLD-1);
      end
      S_DRIVE: begin
        if (cnt_q == '0) state_d = S_VERIFY;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_VERIFY: begin
        state_d   = S_DONE;
        rd_data_d = bank_q;
        err_d     = (op_q != OP_READ) && (bank_q != exp_val);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    drive_d    = (state_d == S_DRIVE);
    gnt_d      = (state_d == S_GRANT) ? (NREQ'(1) << win_d) : '0;
    done_d     = (state_d == S_DONE)  ? (NREQ'(1) << win_d) : '0;
    busy_d     = (state_d != S_IDLE);
    bank_we_d  = drive_d && (op_d == OP_LOAD);
    bank_d_d   = bank_we_d ? data_d : '0;
    bank_clr_d = drive_d && (op_d == OP_CLEAR);
    bank_pre_d = drive_d && (op_d == OP_PRESET);
  end

  // State, latched request and output registers; clr aborts any operation.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      win_q      <= '0;
      op_q       <= OP_LOAD;
      data_q     <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      bank_d_q   <= '0;
      bank_we_q  <= 1'b0;
      bank_pre_q <= 1'b0;
      bank_clr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      win_q      <= win_d;
      op_q       <= op_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      bank_d_q   <= bank_d_d;
      bank_we_q  <= bank_we_d;
      bank_pre_q <= bank_pre_d;
      bank_clr_q <= bank_clr_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign bank_d   = bank_d_q;
  assign bank_we  = bank_we_q;
  assign bank_pre = bank_pre_q;
  assign bank_clr = bank_clr_q;

endmodule

// File: doc/dff_bank_sched.md
Name: dff_bank_sched

Overview:
- Round-robin scheduler that shares one WIDTH-bit bank of preset/clear D flip-flop cells among NREQ requesters.
- Each requester asks for one operation: load, clear, preset or read.
- The block sequences the bank's d/pre/clr/write-enable lines and reads the bank back to check the result.
- It returns done, read data and an error flag to the winning requester.

Parameters:
- WIDTH, 8, bit width of the shared flip-flop bank.
- NREQ, 4, number of requesters (2..8).
- HOLD, 1, cycles the bank control lines are driven per operation (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester request, level; held until matching done.
- req_op  input  2*NREQ  per-requester opcode, slice i = [2i+1:2i]: 00 load, 01 clear, 10 preset, 11 read.
- req_data  input  WIDTH*NREQ  per-requester load data, slice i = [WIDTH*i+WIDTH-1:WIDTH*i].
- bank_q  input  WIDTH  readback of the bank outputs q.
- gnt  output  NREQ  one-hot grant pulse, one cycle.
- done  output  NREQ  one-hot completion pulse, one cycle.
- rd_data  output  WIDTH  captured bank_q; valid while done is high.
- err  output  1  readback mismatch; valid while done is high.
- busy  output  1  high in every state except IDLE.
- bank_d  output  WIDTH  data lines to the bank.
- bank_we  output  1  bank load strobe.
- bank_pre  output  1  bank preset, all bits to 1.
- bank_clr  output  1  bank clear, all bits to 0.

Behaviour:
- All outputs registered; all are 0 on reset. Reset also forces state=IDLE and rr_ptr=0.
- clr high mid-operation aborts the operation: no done pulse, bank lines drop to 0 on the next edge.
- FSM states: IDLE, GRANT, DRIVE, VERIFY, DONE.
- IDLE: if any req bit is set at an edge, pick the winner, latch its index, opcode and data, and go to GRANT. Otherwise stay.
- Arbitration: search from index rr_ptr upward, wrapping mod NREQ; the first set bit wins. On winning, rr_ptr becomes winner+1 mod NREQ.
- GRANT: gnt[winner]=1 for exactly this cycle; next state DRIVE; hold counter loaded with HOLD-1.
- DRIVE: lines held for HOLD cycles, then VERIFY. Lines per opcode:
  - load: bank_we=1, bank_d=latched data.
  - clear: bank_clr=1.
  - preset: bank_pre=1.
  - read: all lines 0.
- bank_pre and bank_clr are never high together. Outside DRIVE, bank_we, bank_pre and bank_clr are 0.
- VERIFY: one cycle. Capture bank_q into rd_data. Expected value per opcode:
  - load: latched data.
  - clear: 0.
  - preset: all ones.
  - read: no check, err=0.
  - err = (bank_q != expected).
- DONE: done[winner]=1 for one cycle with rd_data and err stable; next state IDLE.
- Latency: req sampled at edge k gives gnt in cycle k+1 and done in cycle k+3+HOLD. Back-to-back service: the next grant comes 5+HOLD-1 cycles after the previous one.
- Requests arriving while busy are ignored until IDLE; they are not queued beyond the level of req.
- req dropped after grant: the operation still completes and done still pulses.
- req_op/req_data changes after GRANT have no effect (latched).
- A requester whose req is still high in the cycle after its done is treated as a new request. rr_ptr ensures the other pending requesters are served first.

Test Plan:
- Reset: clr=1 for 2 cycles with req=4'b1111 -> gnt=0, done=0, busy=0, all bank lines 0, rd_data=0.
- Load then read, WIDTH=8, HOLD=1:
  - req[0], op=00, data=8'hA5 -> gnt[0] at k+1, bank_we=1 with bank_d=A5 for 1 cycle, done[0] at k+4, err=0.
  - Then op=11 -> rd_data=A5.
- Clear and preset: req[2] op=01 -> bank_clr pulse, rd_data=00, err=0. req[3] op=10 -> bank_pre pulse, rd_data=FF, err=0.
- Fairness: req=4'b1111 held continuously from reset -> grant order 0,1,2,3,0,1; never two gnt bits high together.
- Fault: bank_q stuck at 8'h00, load 8'h3C -> done with err=1 and rd_data=00.
- Abort: assert clr during DRIVE -> bank lines 0 next cycle, no done. After release, req[1] alone gets gnt[1] (rr_ptr reset to 0).
